// File: rtl/iob_rd_align.sv
// IOB read aligner: issues SRAM reads for address-generator requests and realigns the
// 1-cycle-late read data (pad positions zero-filled) into a FWFT FIFO for the PE array.
// Optional performance counters are enabled with IOB_RD_ALIGN_PERF_CNT_EN.
module iob_rd_align #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_iob_rd_en,
    input  logic [11:0]       i_iob_raddr,
    input  logic              i_iob_pad_en,
    input  logic              i_group_load_end,
    output logic              o_agu_stall,
    output logic              o_sram_rd,
    output logic [11:0]       o_sram_addr,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [DATA_W-1:0] o_pe_data,
    output logic              o_pe_vld,
    output logic              o_pe_last,
    input  logic              i_pe_rdy,
    output logic              o_ovf_err
`ifdef IOB_RD_ALIGN_PERF_CNT_EN
    ,
    output logic [15:0]       o_pad_cnt,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              pend_vld_reg;
    logic              pend_pad_reg;
    logic              pend_last_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  occ_reg;
    logic              ovf_reg;
    logic [DATA_W:0]   mem_reg [DEPTH];

    logic              accept;
    logic              push;
    logic              pop;
    logic              stall;
    logic [CNT_W-1:0]  fill;
    logic [DATA_W:0]   head;

    // Stall one slot early so the word already in the pending stage always fits.
    assign fill   = occ_reg + CNT_W'(pend_vld_reg);
    assign stall  = (fill >= CNT_W'(DEPTH - 1));
    assign accept = i_iob_rd_en & ~stall & ~i_flush & i_rst_n;
    assign push   = pend_vld_reg & ~i_flush;

    assign o_agu_stall = stall;
    assign o_sram_rd   = accept & ~i_iob_pad_en;
    assign o_sram_addr = o_sram_rd ? i_iob_raddr : 12'h000;

    assign head      = mem_reg[rd_ptr_reg];
    assign o_pe_vld  = (occ_reg != '0);
    assign pop       = o_pe_vld & i_pe_rdy;
    assign o_pe_data = o_pe_vld ? head[DATA_W-1:0] : {DATA_W{1'b0}};
    assign o_pe_last = o_pe_vld & head[DATA_W];
    assign o_ovf_err = ovf_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            pend_vld_reg  <= 1'b0;
            pend_pad_reg  <= 1'b0;
            pend_last_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
        end else begin
            pend_vld_reg  <= accept;
            pend_pad_reg  <= i_iob_pad_en;
            pend_last_reg <= i_group_load_end;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + CNT_W'(1);
                2'b01:   occ_reg <= occ_reg - CNT_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // Storage is left unreset; the occupancy gate keeps stale contents off the outputs.
    always_ff @(posedge i_clk) begin
        if (push)
            mem_reg[wr_ptr_reg] <= {pend_last_reg, pend_pad_reg ? {DATA_W{1'b0}} : i_sram_rdata};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            ovf_reg <= 1'b0;
        else if (i_iob_rd_en && stall)
            ovf_reg <= 1'b1;
    end

`ifdef IOB_RD_ALIGN_PERF_CNT_EN
    logic [15:0] pad_cnt_reg;
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            pad_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (accept && i_iob_pad_en && pad_cnt_reg != 16'hFFFF)
                pad_cnt_reg <= pad_cnt_reg + 16'd1;
            if (stall && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign o_pad_cnt   = pad_cnt_reg;
    assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_iob_rd_align.sv
// Scoreboard bench for iob_rd_align: expected words are queued at request time and
// compared as the PE side pops them.
module tb_iob_rd_align;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          rd_en = 1'b0;
    logic [11:0]   raddr = '0;
    logic          pad_en = 1'b0;
    logic          gle = 1'b0;
    logic          agu_stall;
    logic          sram_rd;
    logic [11:0]   sram_addr;
    logic [DW-1:0] sram_rdata = '0;
    logic [DW-1:0] pe_data;
    logic          pe_vld;
    logic          pe_last;
    logic          pe_rdy = 1'b0;
    logic          ovf_err;
`ifdef IOB_RD_ALIGN_PERF_CNT_EN
    logic [15:0]   pad_cnt;
    logic [15:0]   stall_cnt;
`endif

    logic [DW-1:0] sram_val = '0;
    logic [DW:0]   exp_q [$];
    int            checks = 0;
    int            errors = 0;

    iob_rd_align #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_iob_rd_en      (rd_en),
        .i_iob_raddr      (raddr),
        .i_iob_pad_en     (pad_en),
        .i_group_load_end (gle),
        .o_agu_stall      (agu_stall),
        .o_sram_rd        (sram_rd),
        .o_sram_addr      (sram_addr),
        .i_sram_rdata     (sram_rdata),
        .o_pe_data        (pe_data),
        .o_pe_vld         (pe_vld),
        .o_pe_last        (pe_last),
        .i_pe_rdy         (pe_rdy),
        .o_ovf_err        (ovf_err)
`ifdef IOB_RD_ALIGN_PERF_CNT_EN
        ,
        .o_pad_cnt        (pad_cnt),
        .o_stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: data one cycle after the strobe, garbage otherwise so pad zeroing is visible.
    always @(posedge clk) begin
        if (sram_rd)
            sram_rdata <= sram_val;
        else
            sram_rdata <= {$urandom, $urandom};
    end

    always @(negedge clk) begin
        if (pe_vld === 1'b1 && pe_rdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got data=%h last=%b required no word", pe_data, pe_last);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({pe_last, pe_data} !== e) begin
                    errors++;
                    $display("FAIL pe_word got data=%h last=%b required data=%h last=%b",
                             pe_data, pe_last, e[DW-1:0], e[DW]);
                end else begin
                    $display("pop data=%h last=%b", pe_data, pe_last);
                end
            end
        end
    end

    task automatic req(input logic [11:0] addr, input logic pad, input logic last, input logic [DW-1:0] data);
        rd_en = 1'b1; raddr = addr; pad_en = pad; gle = last; sram_val = data;
        @(negedge clk);
        checks++;
        if (agu_stall !== 1'b0) begin
            errors++;
            $display("FAIL req_stall addr=%h got %b required 0", addr, agu_stall);
        end
        checks++;
        if (sram_rd !== ~pad || sram_addr !== (pad ? 12'h000 : addr)) begin
            errors++;
            $display("FAIL req_sram addr=%h got rd=%b addr=%h required rd=%b addr=%h",
                     addr, sram_rd, sram_addr, ~pad, pad ? 12'h000 : addr);
        end
        exp_q.push_back({last, pad ? {DW{1'b0}} : data});
        $display("req addr=%h pad=%b last=%b data=%h", addr, pad, last, data);
        @(posedge clk); #1;
        rd_en = 1'b0; pad_en = 1'b0; gle = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d words left required 0", name, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (pe_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_vld got %b required 0", name, pe_vld);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string name, input logic exp_ovf);
        checks++;
        if (pe_vld !== 1'b0 || pe_last !== 1'b0 || pe_data !== '0 || agu_stall !== 1'b0 ||
            sram_rd !== 1'b0 || sram_addr !== 12'h000 || ovf_err !== exp_ovf) begin
            errors++;
            $display("FAIL %s got vld=%b last=%b data=%h stall=%b rd=%b addr=%h ovf=%b required zeros ovf=%b",
                     name, pe_vld, pe_last, pe_data, agu_stall, sram_rd, sram_addr, ovf_err, exp_ovf);
        end
`ifdef IOB_RD_ALIGN_PERF_CNT_EN
        checks++;
        if (pad_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s_perf got pad=%0d stall=%0d required 0 0", name, pad_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_reset;
        pe_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset", 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        pe_rdy = 1'b1;
        req(12'h005, 1'b0, 1'b0, 64'h55);
        @(negedge clk);
        checks++;
        if (pe_vld !== 1'b0) begin
            errors++;
            $display("FAIL latency_cycle1 got vld=%b required 0", pe_vld);
        end
        @(negedge clk);
        checks++;
        if (pe_vld !== 1'b1) begin
            errors++;
            $display("FAIL latency_cycle2 got vld=%b required 1", pe_vld);
        end
        wait_drain("latency");
    endtask

    task automatic test_basic;
        pe_rdy = 1'b1;
        for (int i = 0; i < 4; i++)
            req(12'h010 + 12'(i), 1'b0, 1'b0, 64'hA0 + 64'(i));
        wait_drain("basic");
    endtask

    task automatic test_pad;
`ifdef IOB_RD_ALIGN_PERF_CNT_EN
        logic [15:0] pad_before;
        pad_before = pad_cnt;
`endif
        pe_rdy = 1'b1;
        req(12'h020, 1'b1, 1'b0, 64'hDEAD);
        req(12'h020, 1'b0, 1'b0, 64'hB0);
        req(12'h020, 1'b1, 1'b0, 64'hBEEF);
        req(12'h020, 1'b0, 1'b0, 64'hB1);
        wait_drain("pad");
`ifdef IOB_RD_ALIGN_PERF_CNT_EN
        checks++;
        if (pad_cnt !== pad_before + 16'd2) begin
            errors++;
            $display("FAIL pad_cnt got %0d required %0d", pad_cnt, pad_before + 16'd2);
        end
`endif
    endtask

    task automatic test_last;
        pe_rdy = 1'b1;
        gle = 1'b1;
        @(posedge clk); #1;
        gle = 1'b0;
        req(12'h040, 1'b0, 1'b0, 64'hD0);
        req(12'h041, 1'b0, 1'b0, 64'hD1);
        req(12'h042, 1'b0, 1'b1, 64'hD2);
        wait_drain("last");
    endtask

    task automatic fill_three(input logic [7:0] base);
        pe_rdy = 1'b0;
        for (int i = 0; i < 3; i++)
            req(12'h030 + 12'(i), 1'b0, 1'b0, 64'(base) + 64'(i));
    endtask

    task automatic test_backpressure;
        fill_three(8'hC0);
        @(negedge clk);
        checks++;
        if (agu_stall !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall_rise got %b required 1", agu_stall);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (agu_stall !== 1'b1 || pe_vld !== 1'b1 || pe_data !== 64'hC0) begin
            errors++;
            $display("FAIL bp_hold got stall=%b vld=%b data=%h required 1 1 c0", agu_stall, pe_vld, pe_data);
        end
        @(posedge clk); #1;
        pe_rdy = 1'b1;
        wait_drain("bp");
        @(negedge clk);
        checks++;
        if (agu_stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_drop got %b required 0", agu_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        fill_three(8'hE0);
        rd_en = 1'b1; raddr = 12'h0FF; sram_val = 64'h99;
        @(negedge clk);
        checks++;
        if (agu_stall !== 1'b1 || sram_rd !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop got stall=%b rd=%b required 1 0", agu_stall, sram_rd);
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b required 1", ovf_err);
        end
        @(posedge clk); #1;
        pe_rdy = 1'b1;
        wait_drain("ovf");
    endtask

    task automatic test_flush;
        fill_three(8'hF0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs("flush", 1'b1);
        @(posedge clk); #1;
        pe_rdy = 1'b1;
        rd_en = 1'b1; raddr = 12'h050; sram_val = 64'h77; flush = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pe_vld !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale cycle=%0d got vld=%b required 0", i, pe_vld);
            end
        end
        @(posedge clk); #1;
        req(12'h060, 1'b0, 1'b1, 64'h1234);
        wait_drain("post_flush");
    endtask

    task automatic test_reset_midburst;
        fill_three(8'h80);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        pe_rdy = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset", 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pe_vld !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale cycle=%0d got vld=%b required 0", i, pe_vld);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_pad();
        test_last();
        test_backpressure();
        test_overflow();
        test_flush();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
